seven_segment_capture: RTL and testbench
========================================

# seven_segment_capture

Receiving end of the 4-digit multiplexed seven-segment interface: samples the active-low anode and segment lines driven toward the Basys3 display, debounces the scan, decodes each digit's segment pattern back to its hex value, and holds a per-digit picture of what the display currently shows. It sits in the simulator and verification path beside the display drivers, turning raw pin activity into digit values, blank and valid flags, and error events for checkers and the GUI bridge.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples of {an, seg} required before a commit; legal range ≥ 1.
- BLANK_TIMEOUT, 1024: cycles without a commit or continued stable selection of a digit before that digit is declared blank; legal range ≥ 2.

- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- an  in  4  digit select, active-low; bit i low selects digit i.
- seg  in  7  segments {cg,cf,ce,cd,cc,cb,ca}, active-low.
- digits  out  16  decoded values; digit i is digits[4i+3:4i].
- valid  out  4  bit i high means digits[i] holds a legal decode currently shown.
- blank  out  4  bit i high means digit i is dark: all segments off, or timed out.
- update  out  1  one-cycle pulse on any edge where digits, valid or blank changed.
- err  out  1  one-cycle pulse on a commit of an illegal condition.

## Operation
- Input register s_reg samples {an,seg} every edge. Run counter: 1 on the first edge a new value is sampled, incremented while the sample equals s_reg, saturating at STABLE_CYCLES.
- Commit fires once per run, on the edge where the run counter reaches STABLE_CYCLES. With STABLE_CYCLES=1, it fires on every changed sample. Holding the value does not recommit.
- Commit actions, where i is the single low bit of an:
  - seg matches the decode table: digits[i] ← value, valid[i] ← 1, blank[i] ← 0.
  - seg = 7'h7F: blank[i] ← 1, valid[i] ← 0, digits[i] unchanged.
  - Any other seg: valid[i] ← 0, blank[i] unchanged, err pulse.
  - an = 4'hF: no action, no err.
  - Two or more bits of an low: err pulse, no digit state change.
- Decode table (seg → value): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F. All other codes are illegal.
- Per-digit timeout counters, one per digit:
  - Cleared on any commit to digit i.
  - Held at 0 while the committed run selecting digit i continues.
  - Otherwise incremented, saturating.
  - On reaching BLANK_TIMEOUT: valid[i] ← 0, blank[i] ← 1, digits[i] unchanged.
- update is the OR, over the current edge, of any change to digits, valid or blank.

## Timing
- Reset values: digits = 16'h0000, valid = 4'b0000, blank = 4'b1111, update = 0, err = 0. Run counter, s_reg and all timeout counters are cleared.
- Reset is asynchronous and may assert mid-run; the run restarts from 1 on the first edge after release.
- Latency: an input applied before edge k and held produces updated outputs, update and err registered after edge k+STABLE_CYCLES−1.
- A change of {an,seg} before the commit edge restarts the run. Glitches shorter than STABLE_CYCLES samples have no effect.
- A timeout expiry on the same edge as a commit for the same digit: the commit wins and the counter clears.
- A timeout expiry on one digit and a commit on another in the same edge: both take effect, with a single update pulse.
- update and err are never asserted for more than one consecutive cycle per event.

## Test plan
- Reset, then drive an=4'b1110, seg=7'h24 for 4 cycles → on the 4th edge digits[3:0]=2, valid=4'b0001, blank=4'b1110, one update pulse. Holding the value 100 more cycles → no further pulses.
- Scan an=1110/1101/1011/0111 with seg 79/30/12/0E, 8 cycles each, looping → digits=16'hF531, valid=4'hF, no timeouts.
- Glitch: a 3-cycle seg=7'h00 inside a stable seg=7'h40 on digit 1 → digit 1 stays 0, no update.
- an=4'b1100 held 4 cycles → one err pulse, state unchanged. seg=7'h7E on digit 2 → err pulse, valid[2]=0.
- Stop scanning digit 3 after it shows E → exactly BLANK_TIMEOUT cycles after its run ends, valid[3]=0, blank[3]=1, digits[15:12] remain E, one update pulse.
- Assert rst_n low mid-run on the 3rd stable cycle → outputs return to reset values immediately, and no commit follows release until 4 fresh samples.

Source files
------------

// File: rtl/seven_segment_capture.sv
// Capture side of a 4-digit multiplexed seven-segment display: debounces the
// {an, seg} scan, decodes each committed digit and tracks per-digit blank timeouts.
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLANK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  blank,
    output logic        update,
    output logic        err
);

    localparam int unsigned RW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(BLANK_TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_MAX  = TW'(BLANK_TIMEOUT);
    localparam logic [6:0]    SEG_OFF = 7'h7F;

    logic [10:0]         s_reg;
    logic [RW-1:0]       run_cnt;
    logic [RW-1:0]       run_nxt;
    logic [3:0][TW-1:0]  to_cnt;
    logic [3:0][TW-1:0]  to_nxt;
    logic [15:0]         digits_nxt;
    logic [3:0]          valid_nxt;
    logic [3:0]          blank_nxt;
    logic                update_nxt;
    logic                err_nxt;

    logic                changed_c;
    logic                commit_c;
    logic                held_run_c;
    logic [3:0]          sel_c;
    logic [3:0]          held_sel_c;
    logic                sel_onehot_c;
    logic                held_onehot_c;
    logic                legal_c;
    logic [3:0]          value_c;

    // Active-low segment pattern back to its hex value.
    always_comb begin
        legal_c = 1'b1;
        value_c = 4'h0;
        case (seg)
            7'h40: value_c = 4'h0;
            7'h79: value_c = 4'h1;
            7'h24: value_c = 4'h2;
            7'h30: value_c = 4'h3;
            7'h19: value_c = 4'h4;
            7'h12: value_c = 4'h5;
            7'h02: value_c = 4'h6;
            7'h78: value_c = 4'h7;
            7'h00: value_c = 4'h8;
            7'h10: value_c = 4'h9;
            7'h08: value_c = 4'hA;
            7'h03: value_c = 4'hB;
            7'h46: value_c = 4'hC;
            7'h21: value_c = 4'hD;
            7'h06: value_c = 4'hE;
            7'h0E: value_c = 4'hF;
            default: legal_c = 1'b0;
        endcase
    end

    // Run tracking: commit exactly once, on the edge the run reaches STABLE_CYCLES.
    always_comb begin
        changed_c = ({an, seg} != s_reg);
        if (changed_c) begin
            run_nxt = RW'(1);
        end else if (run_cnt == RUN_MAX) begin
            run_nxt = run_cnt;
        end else begin
            run_nxt = run_cnt + RW'(1);
        end
        commit_c      = (run_nxt == RUN_MAX) && (changed_c || (run_cnt != RUN_MAX));
        held_run_c    = !changed_c && (run_cnt == RUN_MAX);
        sel_c         = ~an;
        held_sel_c    = ~s_reg[10:7];
        sel_onehot_c  = (sel_c != 4'h0) && ((sel_c & (sel_c - 4'd1)) == 4'h0);
        held_onehot_c = (held_sel_c != 4'h0) && ((held_sel_c & (held_sel_c - 4'd1)) == 4'h0);
    end

    // Per-digit commit and timeout handling; a commit to a digit overrides its expiry.
    always_comb begin
        digits_nxt = digits;
        valid_nxt  = valid;
        blank_nxt  = blank;
        to_nxt     = to_cnt;
        err_nxt    = 1'b0;

        if (commit_c && (an != 4'hF)) begin
            err_nxt = !sel_onehot_c || (!legal_c && (seg != SEG_OFF));
        end

        for (int i = 0; i < 4; i++) begin
            if ((commit_c && sel_onehot_c && sel_c[i]) ||
                (held_run_c && held_onehot_c && held_sel_c[i])) begin
                to_nxt[i] = '0;
            end else if (to_cnt[i] != TO_MAX) begin
                to_nxt[i] = to_cnt[i] + TW'(1);
            end

            if (commit_c && sel_onehot_c && sel_c[i]) begin
                if (legal_c) begin
                    digits_nxt[4*i +: 4] = value_c;
                    valid_nxt[i]         = 1'b1;
                    blank_nxt[i]         = 1'b0;
                end else if (seg == SEG_OFF) begin
                    valid_nxt[i] = 1'b0;
                    blank_nxt[i] = 1'b1;
                end else begin
                    valid_nxt[i] = 1'b0;
                end
            end else if ((to_nxt[i] == TO_MAX) && (to_cnt[i] != TO_MAX)) begin
                valid_nxt[i] = 1'b0;
                blank_nxt[i] = 1'b1;
            end
        end

        update_nxt = (digits_nxt != digits) || (valid_nxt != valid) || (blank_nxt != blank);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= '0;
            run_cnt <= '0;
            to_cnt  <= '0;
            digits  <= 16'h0000;
            valid   <= 4'b0000;
            blank   <= 4'b1111;
            update  <= 1'b0;
            err     <= 1'b0;
        end else begin
            s_reg   <= {an, seg};
            run_cnt <= run_nxt;
            to_cnt  <= to_nxt;
            digits  <= digits_nxt;
            valid   <= valid_nxt;
            blank   <= blank_nxt;
            update  <= update_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture with default parameters.
module tb_seven_segment_capture;

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        update;
    logic        err;

    int n_checks;
    int n_fails;
    int upd_cnt;
    int err_cnt;

    seven_segment_capture #(
        .STABLE_CYCLES(4),
        .BLANK_TIMEOUT(1024)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .an     (an),
        .seg    (seg),
        .digits (digits),
        .valid  (valid),
        .blank  (blank),
        .update (update),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply {a, s} and advance n edges, sampling 1 time unit after each edge.
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) begin
            @(posedge clk);
            #1;
            upd_cnt += int'(update);
            err_cnt += int'(err);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        upd_cnt  = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        an       = 4'hF;
        seg      = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        check("rst_digits", 32'(digits), 32'h0000);
        check("rst_valid",  32'(valid),  32'h0);
        check("rst_blank",  32'(blank),  32'hF);
        check("rst_update", 32'(update), 32'h0);
        check("rst_err",    32'(err),    32'h0);
        rst_n = 1'b1;
        drive(4'hF, 7'h7F, 6);
        check("idle_pulses", 32'(upd_cnt + err_cnt), 32'h0);

        // Single digit commit latency.
        upd_cnt = 0;
        drive(4'b1110, 7'h24, 3);
        check("pre_commit_valid", 32'(valid), 32'h0);
        drive(4'b1110, 7'h24, 1);
        check("commit_update", 32'(update), 32'h1);
        check("commit_digits", 32'(digits), 32'h0002);
        check("commit_valid",  32'(valid),  32'h1);
        check("commit_blank",  32'(blank),  32'hE);
        drive(4'b1110, 7'h24, 100);
        check("hold_no_recommit", 32'(upd_cnt), 32'h1);

        // Full scan loop.
        upd_cnt = 0;
        err_cnt = 0;
        for (int l = 0; l < 3; l++) begin
            drive(4'b1110, 7'h79, 8);
            drive(4'b1101, 7'h30, 8);
            drive(4'b1011, 7'h12, 8);
            drive(4'b0111, 7'h0E, 8);
        end
        check("scan_digits",  32'(digits),  32'hF531);
        check("scan_valid",   32'(valid),   32'hF);
        check("scan_blank",   32'(blank),   32'h0);
        check("scan_updates", 32'(upd_cnt), 32'h4);
        check("scan_errs",    32'(err_cnt), 32'h0);

        // Glitch shorter than the debounce window.
        drive(4'b1101, 7'h40, 8);
        check("d1_zero", 32'(digits), 32'hF501);
        upd_cnt = 0;
        drive(4'b1101, 7'h00, 3);
        drive(4'b1101, 7'h40, 8);
        check("glitch_digits",  32'(digits),  32'hF501);
        check("glitch_updates", 32'(upd_cnt), 32'h0);

        // Multiple anodes low, then an illegal pattern.
        upd_cnt = 0;
        err_cnt = 0;
        drive(4'b1100, 7'h40, 3);
        check("multi_an_early", 32'(err_cnt), 32'h0);
        drive(4'b1100, 7'h40, 1);
        check("multi_an_err_pulse", 32'(err), 32'h1);
        drive(4'b1100, 7'h40, 4);
        check("multi_an_errs",   32'(err_cnt), 32'h1);
        check("multi_an_digits", 32'(digits),  32'hF501);
        check("multi_an_valid",  32'(valid),   32'hF);
        check("multi_an_upd",    32'(upd_cnt), 32'h0);
        err_cnt = 0;
        drive(4'b1011, 7'h7E, 6);
        check("illegal_errs",   32'(err_cnt), 32'h1);
        check("illegal_valid",  32'(valid),   32'hB);
        check("illegal_blank",  32'(blank),   32'h0);
        check("illegal_digits", 32'(digits),  32'hF501);
        check("illegal_upd",    32'(upd_cnt), 32'h1);

        // All-off pattern blanks the digit without touching its value.
        err_cnt = 0;
        drive(4'b1110, 7'h7F, 6);
        check("off_valid",  32'(valid),   32'hA);
        check("off_blank",  32'(blank),   32'h1);
        check("off_digits", 32'(digits),  32'hF501);
        check("off_errs",   32'(err_cnt), 32'h0);

        // Timeout of digit 3 after its scan stops.
        drive(4'b0111, 7'h06, 8);
        check("d3_e_digits", 32'(digits), 32'hE501);
        check("d3_e_valid",  32'(valid[3]), 32'h1);
        drive(4'hF, 7'h7F, 1023);
        check("to_before_valid", 32'(valid[3]), 32'h1);
        check("to_before_blank", 32'(blank[3]), 32'h0);
        upd_cnt = 0;
        drive(4'hF, 7'h7F, 1);
        check("to_update", 32'(update),   32'h1);
        check("to_valid",  32'(valid),    32'h0);
        check("to_blank",  32'(blank),    32'hF);
        check("to_digits", 32'(digits),   32'hE501);
        drive(4'hF, 7'h7F, 5);
        check("to_one_pulse", 32'(upd_cnt), 32'h1);

        // Reset in the middle of a run.
        drive(4'b1110, 7'h00, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_digits", 32'(digits), 32'h0000);
        check("midrst_valid",  32'(valid),  32'h0);
        check("midrst_blank",  32'(blank),  32'hF);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        upd_cnt = 0;
        drive(4'b1110, 7'h00, 3);
        check("postrst_no_commit", 32'(upd_cnt), 32'h0);
        check("postrst_valid0",    32'(valid),   32'h0);
        drive(4'b1110, 7'h00, 1);
        check("postrst_update", 32'(update), 32'h1);
        check("postrst_digits", 32'(digits), 32'h0008);
        check("postrst_valid",  32'(valid),  32'h1);
        check("postrst_blank",  32'(blank),  32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
